// File: rtl/breakout_pkg.sv
// Shared breakout definitions: screen size, pixel coordinate/colour types and paddle geometry,
// plus the clamped span-edge helpers used by the paddle drawer.
package breakout_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam int PADDLE_HALF_W = 40;
  localparam int PADDLE_HEIGHT = 4;
  localparam int PADDLE_Y_TOP  = 460;

  typedef logic [2:0] colour_t;
  typedef logic [9:0] xcoord_t;
  typedef logic [8:0] ycoord_t;

  localparam colour_t PADDLE_FG = 3'b111;
  localparam colour_t PADDLE_BG = 3'b000;

  // Left edge of a span centred on centre, clamped at column 0.
  function automatic xcoord_t span_left(xcoord_t centre, int half_w);
    logic signed [11:0] v;
    v = $signed({2'b00, centre}) - $signed(12'(half_w));
    if (v < 0) v = '0;
    return v[9:0];
  endfunction

  // Right edge of a span; widened so centre+half_w cannot wrap before the clamp.
  function automatic xcoord_t span_right(xcoord_t centre, int half_w, int screen_w);
    logic signed [11:0] v;
    v = $signed({2'b00, centre}) + $signed(12'(half_w)) - 12'sd1;
    if (v > $signed(12'(screen_w - 1))) v = $signed(12'(screen_w - 1));
    return v[9:0];
  endfunction

endpackage

// File: rtl/paddle_draw_if.sv
// Paddle drawer bus: position/tick in from the paddle stage, pixel-write port out to the VGA adapter.
interface paddle_draw_if;
  import breakout_pkg::*;

  xcoord_t paddle_x;
  logic    frame_tick;
  xcoord_t vga_x;
  ycoord_t vga_y;
  colour_t colour;
  logic    plot;
  logic    busy;
  logic    done;

  modport master (
    input  paddle_x, frame_tick,
    output vga_x, vga_y, colour, plot, busy, done
  );

  modport slave (
    output paddle_x, frame_tick,
    input  vga_x, vga_y, colour, plot, busy, done
  );
endinterface

// File: rtl/paddle_draw_span_scan.sv
// Row-major raster counter: on start it presents (x_lo, y_lo) in the next cycle and then walks
// one pixel per clock to (x_hi, y_hi); an empty rectangle never raises valid.
module span_scan
  import breakout_pkg::*;
(
  input  logic    clk,
  input  logic    resetn,
  input  logic    start,
  input  xcoord_t x_lo,
  input  xcoord_t x_hi,
  input  ycoord_t y_lo,
  input  ycoord_t y_hi,
  output xcoord_t x,
  output ycoord_t y,
  output logic    valid,
  output logic    last
);

  xcoord_t x_q, x_d;
  ycoord_t y_q, y_d;
  logic    valid_q, valid_d;

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    valid_d = valid_q;
    if (start) begin
      x_d     = x_lo;
      y_d     = y_lo;
      valid_d = (x_lo <= x_hi) && (y_lo <= y_hi);
    end else if (valid_q) begin
      if (x_q != x_hi) begin
        x_d = x_q + 10'd1;
      end else if (y_q != y_hi) begin
        x_d = x_lo;
        y_d = y_q + 9'd1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign x     = x_q;
  assign y     = y_q;
  assign valid = valid_q;
  assign last  = valid_q && (x_q == x_hi) && (y_q == y_hi);

endmodule

// File: rtl/paddle_draw.sv
// Paddle rasteriser: on an accepted frame tick redraws the paddle one pixel per clock.
// Define PADDLE_DRAW_ERASE_EN to overwrite the previous span with BG before drawing.
module paddle_draw
  import breakout_pkg::colour_t, breakout_pkg::xcoord_t, breakout_pkg::ycoord_t,
         breakout_pkg::span_left, breakout_pkg::span_right;
#(
  parameter int      HALF_W   = breakout_pkg::PADDLE_HALF_W,
  parameter int      HEIGHT   = breakout_pkg::PADDLE_HEIGHT,
  parameter int      Y_TOP    = breakout_pkg::PADDLE_Y_TOP,
  parameter int      SCREEN_W = breakout_pkg::SCREEN_W,
  parameter colour_t FG       = breakout_pkg::PADDLE_FG,
  parameter colour_t BG       = breakout_pkg::PADDLE_BG
) (
  input logic           clk,
  input logic           resetn,
  paddle_draw_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW, S_FIN} state_t;

  // Rows at or below the bottom of the screen are dropped from the scan rectangle.
  localparam int Y_BOT_RAW = Y_TOP + HEIGHT - 1;
  localparam int Y_BOT     = (Y_BOT_RAW > breakout_pkg::SCREEN_H - 1) ?
                             breakout_pkg::SCREEN_H - 1 : Y_BOT_RAW;
  localparam ycoord_t Y_LO = ycoord_t'(Y_TOP);
  localparam ycoord_t Y_HI = ycoord_t'(Y_BOT);

  state_t  state_q, state_d;
  xcoord_t target_q, target_d;
  xcoord_t drawn_x_q, drawn_x_d;
  logic    drawn_valid_q, drawn_valid_d;
  colour_t colour_q, colour_d;
  logic    busy_q, busy_d;
  logic    done_q, done_d;

  logic    scan_start;
  xcoord_t scan_centre;
  xcoord_t scan_x;
  ycoord_t scan_y;
  logic    scan_valid;
  logic    scan_last;
  logic    scan_end;

  assign scan_end = scan_last || !scan_valid;

  span_scan u_scan (
    .clk    (clk),
    .resetn (resetn),
    .start  (scan_start),
    .x_lo   (span_left(scan_centre, HALF_W)),
    .x_hi   (span_right(scan_centre, HALF_W, SCREEN_W)),
    .y_lo   (Y_LO),
    .y_hi   (Y_HI),
    .x      (scan_x),
    .y      (scan_y),
    .valid  (scan_valid),
    .last   (scan_last)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      target_q      <= '0;
      drawn_x_q     <= '0;
      drawn_valid_q <= 1'b0;
      colour_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      drawn_x_q     <= drawn_x_d;
      drawn_valid_q <= drawn_valid_d;
      colour_q      <= colour_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // scan_centre must already name the next span on the edge that starts it.
  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    drawn_x_d     = drawn_x_q;
    drawn_valid_d = drawn_valid_q;
    scan_start    = 1'b0;
    scan_centre   = target_q;
    case (state_q)
      S_IDLE: begin
        if (bus.frame_tick) begin
          target_d = bus.paddle_x;
          if (drawn_valid_q && (bus.paddle_x == drawn_x_q)) begin
            state_d = S_FIN;
`ifdef PADDLE_DRAW_ERASE_EN
          end else if (drawn_valid_q) begin
            state_d     = S_ERASE;
            scan_start  = 1'b1;
            scan_centre = drawn_x_q;
`endif
          end else begin
            state_d     = S_DRAW;
            scan_start  = 1'b1;
            scan_centre = bus.paddle_x;
          end
        end
      end
`ifdef PADDLE_DRAW_ERASE_EN
      S_ERASE: begin
        if (scan_end) begin
          state_d    = S_DRAW;
          scan_start = 1'b1;
        end else begin
          scan_centre = drawn_x_q;
        end
      end
`endif
      S_DRAW: begin
        if (scan_end) begin
          state_d       = S_FIN;
          drawn_x_d     = target_q;
          drawn_valid_d = 1'b1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_d   = (state_d == S_ERASE) || (state_d == S_DRAW);
    done_d   = (state_d == S_FIN);
    colour_d = colour_q;
    if (state_d == S_ERASE)     colour_d = BG;
    else if (state_d == S_DRAW) colour_d = FG;
  end

  assign bus.vga_x  = scan_x;
  assign bus.vga_y  = scan_y;
  assign bus.plot   = scan_valid;
  assign bus.colour = colour_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_paddle_draw.sv
// Directed bench for paddle_draw: table of frame ticks with hand-computed spans and latencies,
// plus a mid-draw reset sequence. Expectations follow the PADDLE_DRAW_ERASE_EN build setting.
module tb_paddle_draw;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  paddle_draw_if bus ();

  paddle_draw dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

`ifdef PADDLE_DRAW_ERASE_EN
  localparam int ER = 1;
`else
  localparam int ER = 0;
`endif

  typedef struct {
    int px;
    int n_bg;
    int bg_lo;
    int bg_w;
    int n_fg;
    int fg_lo;
    int fg_w;
    int lat;
    int mid_tick;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_tick(input int idx, input vec_t v);
    int cyc, done_at, k, j, ex, ey, ec, n_plot, n_bg, n_fg, bad_px, bad_busy, bad_idle;
    done_at = 0; n_plot = 0; n_bg = 0; n_fg = 0;
    bad_px = 0; bad_busy = 0; bad_idle = 0;
    @(negedge clk);
    bus.paddle_x   = 10'(v.px);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    cyc = 1;
    while (done_at == 0 && cyc <= 2000) begin
      if (bus.plot) begin
        k = n_plot;
        n_plot++;
        if (bus.colour == 3'b000) n_bg++;
        else if (bus.colour == 3'b111) n_fg++;
        if (k < v.n_bg) begin
          ex = v.bg_lo + k % v.bg_w; ey = 460 + k / v.bg_w; ec = 0;
        end else if (k - v.n_bg < v.n_fg) begin
          j = k - v.n_bg;
          ex = v.fg_lo + j % v.fg_w; ey = 460 + j / v.fg_w; ec = 7;
        end else begin
          ex = -1; ey = -1; ec = -1;
        end
        if (int'(bus.vga_x) != ex || int'(bus.vga_y) != ey || int'(bus.colour) != ec)
          bad_px++;
      end
      if (bus.busy != (cyc < v.lat) || bus.plot != (cyc < v.lat)) bad_busy++;
      if (bus.done) begin
        done_at = cyc;
      end else begin
        if (cyc == v.mid_tick) begin
          bus.paddle_x   = 10'd200;
          bus.frame_tick = 1'b1;
        end
        @(negedge clk);
        bus.frame_tick = 1'b0;
        cyc++;
      end
    end
    repeat (3) begin
      @(negedge clk);
      if (bus.plot || bus.done || bus.busy) bad_idle++;
    end
    check($sformatf("v%0d done latency", idx), done_at, v.lat);
    check($sformatf("v%0d bg plots", idx), n_bg, v.n_bg);
    check($sformatf("v%0d fg plots", idx), n_fg, v.n_fg);
    check($sformatf("v%0d pixel order errors", idx), bad_px, 0);
    check($sformatf("v%0d busy/plot window errors", idx), bad_busy, 0);
    check($sformatf("v%0d activity after done", idx), bad_idle, 0);
  endtask

  initial begin
    //          px    n_bg            bg_lo bg_w n_fg fg_lo fg_w lat                 mid
    vecs[0] = '{320,  0,              0,    1,   320, 280,  80,  321,                0};
    vecs[1] = '{321,  (ER != 0) ? 320 : 0, 280, 80, 320, 281, 80, (ER != 0) ? 641 : 321, 0};
    vecs[2] = '{321,  0,              0,    1,   0,   0,    1,   1,                  0};
    vecs[3] = '{20,   (ER != 0) ? 320 : 0, 281, 80, 240, 0,   60, (ER != 0) ? 561 : 241, 0};
    vecs[4] = '{630,  (ER != 0) ? 240 : 0, 0,   60, 200, 590, 50, (ER != 0) ? 441 : 201, 0};
    vecs[5] = '{0,    (ER != 0) ? 200 : 0, 590, 50, 160, 0,   40, (ER != 0) ? 361 : 161, 0};
    vecs[6] = '{100,  (ER != 0) ? 160 : 0, 0,   40, 320, 60,  80, (ER != 0) ? 481 : 321, 5};
    vecs[7] = '{100,  0,              0,    1,   0,   0,    1,   1,                  0};
    vecs[8] = '{300,  0,              0,    1,   320, 260,  80,  321,                0};

    bus.paddle_x   = '0;
    bus.frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    check("reset vga_x", int'(bus.vga_x), 0);
    check("reset vga_y", int'(bus.vga_y), 0);
    check("reset colour", int'(bus.colour), 0);
    check("reset plot", int'(bus.plot), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    resetn = 1'b1;

    for (int i = 0; i < 8; i++) do_tick(i, vecs[i]);

    // Reset in the middle of a draw, then a fresh tick must draw without erasing.
    @(negedge clk);
    bus.paddle_x   = 10'd300;
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    repeat ((ER != 0) ? 329 : 9) @(negedge clk);
    check("mid-draw plot", int'(bus.plot), 1);
    check("mid-draw colour", int'(bus.colour), 7);
    resetn = 1'b0;
    @(negedge clk);
    check("post-reset plot", int'(bus.plot), 0);
    check("post-reset busy", int'(bus.busy), 0);
    check("post-reset done", int'(bus.done), 0);
    resetn = 1'b1;
    do_tick(8, vecs[8]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
